// File: rtl/noc_packet_router_if.sv
// rtl/noc_packet_router_if.sv - input flit stream and per-port output streams of the packet router
// Ports (signals):
//   in_valid/in_ready             input flit handshake
//   dest_addr/pack_type/payload   input flit fields, eop marks the last flit
//   out_valid/out_ready           per-port output handshake (bit p = port p)
//   destination_out               per-port flit, slot p = [p*WIDTH_PACKET +: WIDTH_PACKET]
// Modports: master drives the input stream and consumes the outputs; slave is the router.
interface noc_packet_router_if #(
  parameter int WIDTH_DEST    = 2,
  parameter int WIDTH_TYPE    = 2,
  parameter int WIDTH_PAYLOAD = 8
);
  localparam int NUM_PORTS    = 2 ** WIDTH_DEST;
  localparam int WIDTH_PACKET = WIDTH_DEST + WIDTH_TYPE + WIDTH_PAYLOAD + 1;

  logic                              in_valid;
  logic                              in_ready;
  logic [WIDTH_DEST-1:0]             dest_addr;
  logic [WIDTH_TYPE-1:0]             pack_type;
  logic [WIDTH_PAYLOAD-1:0]          payload;
  logic                              eop;
  logic [NUM_PORTS-1:0]              out_valid;
  logic [NUM_PORTS-1:0]              out_ready;
  logic [NUM_PORTS*WIDTH_PACKET-1:0] destination_out;

  modport master (
    output in_valid, dest_addr, pack_type, payload, eop, out_ready,
    input  in_ready, out_valid, destination_out
  );

  modport slave (
    input  in_valid, dest_addr, pack_type, payload, eop, out_ready,
    output in_ready, out_valid, destination_out
  );
endinterface

// File: rtl/noc_packet_router.sv
// rtl/noc_packet_router.sv - wormhole packet router with one FIFO per output port
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   bus        noc_packet_router_if.slave: input flit stream, per-port output streams
//   burst_err  one-cycle pulse after a packet is truncated at BURST_SIZE flits
//   pkt_count  packets completed at the input (wraps)
module noc_packet_router #(
  parameter int WIDTH_DEST    = 2,
  parameter int WIDTH_TYPE    = 2,
  parameter int WIDTH_PAYLOAD = 8,
  parameter int BURST_SIZE    = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_packet_router_if.slave    bus,
  output logic                  burst_err,
  output logic [15:0]           pkt_count
);
  localparam int NUM_PORTS    = 2 ** WIDTH_DEST;
  localparam int WIDTH_PACKET = WIDTH_DEST + WIDTH_TYPE + WIDTH_PAYLOAD + 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
  localparam int FC_W         = $clog2(BURST_SIZE + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]             state;
  logic [WIDTH_DEST-1:0]  locked_port;
  logic [FC_W-1:0]        flit_cnt;

  logic [WIDTH_PACKET-1:0] mem    [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr [NUM_PORTS];
  logic [PTR_W-1:0]        wr_ptr [NUM_PORTS];
  logic [CNT_W-1:0]        count  [NUM_PORTS];

  logic [NUM_PORTS-1:0]    full;
  logic [NUM_PORTS-1:0]    wr_en;
  logic [NUM_PORTS-1:0]    rd_en;
  logic [WIDTH_DEST-1:0]   target;
  logic                    accept;
  logic                    last_flit;
  logic                    forced;
  logic [WIDTH_PACKET-1:0] flit_in;

  always_comb begin
    full            = '0;
    wr_en           = '0;
    rd_en           = '0;
    bus.out_valid       = '0;
    bus.destination_out = '0;

    for (int p = 0; p < NUM_PORTS; p++) begin
      full[p] = (count[p] == CNT_W'(FIFO_DEPTH));
    end

    // While locked the bus dest_addr is ignored; the whole packet follows its head.
    target       = (state == ST_LOCKED) ? locked_port : bus.dest_addr;
    // Ready looks only at the full flag, so a same-cycle read of a full FIFO
    // does not open it for writing and out_ready never reaches in_ready.
    bus.in_ready = !full[target];
    accept       = bus.in_valid && bus.in_ready;

    // The flit that would reach BURST_SIZE closes the packet even without eop.
    last_flit = (state == ST_LOCKED) ? ((flit_cnt + FC_W'(1)) == FC_W'(BURST_SIZE))
                                     : (BURST_SIZE == 1);
    forced    = !bus.eop && last_flit;
    flit_in   = {target, bus.pack_type, bus.payload, bus.eop | forced};

    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_en[p]         = accept && (target == WIDTH_DEST'(p));
      rd_en[p]         = (count[p] != '0) && bus.out_ready[p];
      bus.out_valid[p] = (count[p] != '0);
      if (count[p] != '0) begin
        bus.destination_out[p*WIDTH_PACKET +: WIDTH_PACKET] = mem[p][rd_ptr[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      locked_port <= '0;
      flit_cnt    <= '0;
      burst_err   <= 1'b0;
      pkt_count   <= '0;
    end else begin
      burst_err <= accept && forced;
      if (accept) begin
        if (bus.eop || last_flit) begin
          state     <= ST_IDLE;
          flit_cnt  <= '0;
          pkt_count <= pkt_count + 16'd1;
        end else if (state == ST_IDLE) begin
          state       <= ST_LOCKED;
          locked_port <= bus.dest_addr;
          flit_cnt    <= FC_W'(1);
        end else begin
          flit_cnt <= flit_cnt + FC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        count[p]  <= '0;
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_en[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
        if (rd_en[p]) rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
        if (wr_en[p] && !rd_en[p]) begin
          count[p] <= count[p] + CNT_W'(1);
        end else if (!wr_en[p] && rd_en[p]) begin
          count[p] <= count[p] - CNT_W'(1);
        end
      end
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr_en[p]) mem[p][wr_ptr[p]] <= flit_in;
    end
  end
endmodule

// File: tb/tb_noc_packet_router.sv
// tb/tb_noc_packet_router.sv - randomized scoreboard bench for noc_packet_router
module tb_noc_packet_router;
  localparam int WD    = 2;
  localparam int NP    = 4;
  localparam int WP    = 13;
  localparam int BURST = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        burst_err;
  logic [15:0] pkt_count;

  noc_packet_router_if #(.WIDTH_DEST(WD), .WIDTH_TYPE(2), .WIDTH_PAYLOAD(8)) bus ();

  noc_packet_router #(
    .WIDTH_DEST(WD), .WIDTH_TYPE(2), .WIDTH_PAYLOAD(8),
    .BURST_SIZE(BURST), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .burst_err(burst_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-port queues of expected flits plus the open packet.
  logic [WP-1:0] q [NP][$];
  int            pkt_len;   // flits accepted in the open packet, 0 = none open
  logic [1:0]    pkt_port;
  logic [15:0]   exp_cnt;
  logic          exp_burst;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) q[p].delete();
    pkt_len   = 0;
    pkt_port  = 2'd0;
    exp_cnt   = 16'd0;
    exp_burst = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare all outputs against the model, advance the model.
  task automatic step(input logic v, input logic [1:0] d, input logic [1:0] t,
                      input logic [7:0] pl, input logic e, input logic [3:0] rdy,
                      output logic acc);
    logic [1:0]    tgt;
    logic          exp_ready;
    logic          cut;
    logic [WP-1:0] exp_slot;
    bus.in_valid  = v;
    bus.dest_addr = d;
    bus.pack_type = t;
    bus.payload   = pl;
    bus.eop       = e;
    bus.out_ready = rdy;
    #1;
    tgt       = (pkt_len == 0) ? d : pkt_port;
    exp_ready = (q[tgt].size() < DEPTH);
    check_eq("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    for (int p = 0; p < NP; p++) begin
      exp_slot = (q[p].size() != 0) ? q[p][0] : '0;
      check_eq($sformatf("out_valid[%0d]", p), 32'(bus.out_valid[p]), 32'(q[p].size() != 0));
      check_eq($sformatf("slot[%0d]", p), 32'(bus.destination_out[p*WP +: WP]), 32'(exp_slot));
    end
    check_eq("burst_err", 32'(burst_err), 32'(exp_burst));
    check_eq("pkt_count", 32'(pkt_count), 32'(exp_cnt));

    acc = v && exp_ready;
    for (int p = 0; p < NP; p++) begin
      if (q[p].size() != 0 && rdy[p]) void'(q[p].pop_front());
    end
    exp_burst = 1'b0;
    if (acc) begin
      cut = !e && (pkt_len + 1 == BURST);
      q[tgt].push_back({tgt, t, pl, e | cut});
      if (e || cut) begin
        pkt_len   = 0;
        exp_cnt   = exp_cnt + 16'd1;
        exp_burst = cut;
      end else begin
        if (pkt_len == 0) pkt_port = d;
        pkt_len++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic acc;
  int   sent;

  initial begin
    bus.in_valid  = 1'b0;
    bus.dest_addr = '0;
    bus.pack_type = '0;
    bus.payload   = '0;
    bus.eop       = 1'b0;
    bus.out_ready = '1;
    model_reset();
    @(posedge clk);
    do_reset();

    // Reset state
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_eq("rst_dest_out", 32'(bus.destination_out), 32'h0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check_eq("rst_pkt_count", 32'(pkt_count), 32'h0);

    // Single flits
    step(1, 2'd1, 2'd1, 8'hAB, 1, 4'hF, acc);
    check_eq("tp1_out_valid", 32'(bus.out_valid), 32'h2);
    check_eq("tp1_slot1", 32'(bus.destination_out[1*WP +: WP]), 32'h0B57);
    check_eq("tp1_pkt_count", 32'(pkt_count), 32'h1);
    step(1, 2'd2, 2'd2, 8'hCD, 1, 4'hF, acc);
    check_eq("tp2_out_valid", 32'(bus.out_valid), 32'h4);
    check_eq("tp2_slot2", 32'(bus.destination_out[2*WP +: WP]), 32'h159B);

    // 3-flit packet to port 3, body flits carry dest_addr=0
    step(1, 2'd3, 2'd0, 8'h10, 0, 4'hF, acc);
    step(1, 2'd0, 2'd0, 8'h11, 0, 4'hF, acc);
    step(1, 2'd0, 2'd0, 8'h12, 1, 4'hF, acc);
    check_eq("tp3_port0_idle", 32'(bus.out_valid[0]), 32'h0);
    check_eq("tp3_slot3", 32'(bus.destination_out[3*WP +: WP]), 32'({2'd3, 2'd0, 8'h12, 1'b1}));
    step(0, 2'd0, 2'd0, 8'h00, 0, 4'hF, acc);

    // 6 flits without eop: truncated at the 4th, flits 5-6 form a new packet
    step(1, 2'd1, 2'd0, 8'h41, 0, 4'hF, acc);
    step(1, 2'd0, 2'd0, 8'h42, 0, 4'hF, acc);
    step(1, 2'd0, 2'd0, 8'h43, 0, 4'hF, acc);
    step(1, 2'd0, 2'd0, 8'h44, 0, 4'hF, acc);
    check_eq("tp4_burst_err", 32'(burst_err), 32'h1);
    check_eq("tp4_slot1", 32'(bus.destination_out[1*WP +: WP]), 32'h0889);
    check_eq("tp4_pkt_count", 32'(pkt_count), 32'h4);
    step(1, 2'd2, 2'd0, 8'h45, 0, 4'hF, acc);
    check_eq("tp4_burst_once", 32'(burst_err), 32'h0);
    step(1, 2'd2, 2'd0, 8'h46, 1, 4'hF, acc);
    step(0, 2'd0, 2'd0, 8'h00, 0, 4'hF, acc);

    // Back-pressure: port 1 stalled, 5 single flits pushed, order kept
    sent = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step(sent < 5, 2'd1, 2'd3, 8'(8'h60 + sent), 1, (cyc < 8) ? 4'b1101 : 4'b1111, acc);
      if (acc) sent++;
    end
    check_eq("flow_sent", 32'(sent), 32'd5);

    // Reset mid-packet with 2 flits buffered on port 0
    step(1, 2'd0, 2'd1, 8'h70, 0, 4'b1110, acc);
    step(1, 2'd3, 2'd1, 8'h71, 0, 4'b1110, acc);
    check_eq("mid_buffered", 32'(bus.out_valid[0]), 32'h1);
    do_reset();
    check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_eq("mid_rst_pkt_count", 32'(pkt_count), 32'h0);
    check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
    step(1, 2'd2, 2'd0, 8'h72, 1, 4'hF, acc);
    check_eq("mid_rst_route", 32'(bus.out_valid), 32'h4);

    // Randomized traffic with occasional stall bursts and resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [3:0] rdy;
      rdy = 4'($urandom) | 4'($urandom);
      if ((cyc / 100) % 4 == 1) rdy = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom), 8'($urandom),
             $urandom_range(0, 3) == 0, rdy, acc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
